uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with 2-flop synchronizer, framing check
module uart_rx #(
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid_out,
  output logic                 rx_busy_out,
  output logic                 rx_frame_err_out
);

  localparam int TW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLING / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [1:0]             fill_q, fill_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   armed_q, armed_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   rx_s;
  logic                   line_ok;

  assign rx_s    = sync_q[1];
  // The synchronizer's reset preset is not a real idle level; arming waits until
  // both stages hold genuine line samples.
  assign line_ok = fill_q[1];

  always_comb begin
    sync_d  = {sync_q[0], rx_serial_in};
    fill_d  = {fill_q[0], 1'b1};
    state_d = state_q;
    tick_d  = tick_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    armed_d = armed_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (rx_s && line_ok) armed_d = 1'b1;
        if (armed_q && !rx_s) state_d = START;
      end
      START: begin
        if (tick_q == HALF_M1) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_q == FULL_M1) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (tick_q == FULL_M1) begin
          tick_d  = '0;
          state_d = IDLE;
          armed_d = rx_s;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data_out      = data_q;
  assign rx_valid_out     = valid_q;
  assign rx_busy_out      = busy_q;
  assign rx_frame_err_out = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int OS = 8;

  logic       clk_in;
  logic       nrst_in;
  logic       rx_serial_in;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_busy_out;
  logic       rx_frame_err_out;

  int checks;
  int failures;
  int valid_cnt;
  int err_cnt;
  int both_cnt;
  logic busy_seen;
  logic [7:0] rx_q[$];

  uart_rx #(.OVERSAMPLING(OS), .DATA_BITS(8)) dut (
    .clk_in           (clk_in),
    .nrst_in          (nrst_in),
    .rx_serial_in     (rx_serial_in),
    .rx_data_out      (rx_data_out),
    .rx_valid_out     (rx_valid_out),
    .rx_busy_out      (rx_busy_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (rx_valid_out) begin
      valid_cnt++;
      rx_q.push_back(rx_data_out);
    end
    if (rx_frame_err_out) err_cnt++;
    if (rx_valid_out && rx_frame_err_out) both_cnt++;
    if (rx_busy_out) busy_seen = 1'b1;
  end

  task automatic drive_bit(input logic b);
    rx_serial_in = b;
    repeat (OS) @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    rx_serial_in = 1'b1;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    nrst_in = 1'b0;
    rx_serial_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (rx_data_out !== 8'h00) begin failures++; $display("FAIL reset_data actual=%h required=00", rx_data_out); end
    checks++; if (rx_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", rx_valid_out); end
    checks++; if (rx_busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", rx_busy_out); end
    checks++; if (rx_frame_err_out !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b required=0", rx_frame_err_out); end
    nrst_in = 1'b1;
    idle(16);
  endtask

  task automatic test_single;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    rx_q.delete();
    send_frame(8'hA5, 1'b1);
    idle(16);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL single_valid_count actual=%0d required=1", valid_cnt - v0); end
    checks++; if (rx_data_out !== 8'hA5) begin failures++; $display("FAIL single_data actual=%h required=a5", rx_data_out); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL single_err actual=%0d required=0", err_cnt - e0); end
    checks++; if (rx_busy_out !== 1'b0) begin failures++; $display("FAIL single_busy_idle actual=%b required=0", rx_busy_out); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [16];
    int e0;
    bytes = '{8'h00, 8'hFF, 8'h23, 8'hAB, 8'h01, 8'h80, 8'h55, 8'hAA,
              8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h7E, 8'h81, 8'h96, 8'h69};
    e0 = err_cnt;
    rx_q.delete();
    for (int i = 0; i < 16; i++) send_frame(bytes[i], 1'b1);
    idle(24);
    checks++; if (rx_q.size() !== 16) begin failures++; $display("FAIL b2b_count actual=%0d required=16", rx_q.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < rx_q.size()) begin
        checks++; if (rx_q[i] !== bytes[i]) begin failures++; $display("FAIL b2b_byte%0d actual=%h required=%h", i, rx_q[i], bytes[i]); end
      end
    end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL b2b_err actual=%0d required=0", err_cnt - e0); end
  endtask

  task automatic test_glitch;
    int v0, e0, waited;
    v0 = valid_cnt; e0 = err_cnt;
    busy_seen = 1'b0;
    rx_serial_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rx_serial_in = 1'b1;
    waited = 0;
    repeat (OS / 2 + 3) begin
      @(posedge clk_in);
      #1;
      waited++;
    end
    checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise actual=%b required=1", busy_seen); end
    checks++; if (rx_busy_out !== 1'b0) begin failures++; $display("FAIL glitch_busy_fall actual=%b required=0 after %0d cycles", rx_busy_out, waited); end
    idle(16);
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL glitch_valid actual=%0d required=0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_err actual=%0d required=0", err_cnt - e0); end
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    rx_q.delete();
    send_frame(8'h3C, 1'b0);
    rx_serial_in = 1'b0;
    repeat (20 * OS) @(posedge clk_in);
    #1;
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ferr_count actual=%0d required=1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL ferr_valid actual=%0d required=0", valid_cnt - v0); end
    checks++; if (rx_data_out !== 8'h69) begin failures++; $display("FAIL ferr_data_held actual=%h required=69", rx_data_out); end
    idle(4 * OS);
    send_frame(8'h5A, 1'b1);
    idle(16);
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL ferr_recover_count actual=%0d required=1", rx_q.size()); end
    checks++; if (rx_data_out !== 8'h5A) begin failures++; $display("FAIL ferr_recover_data actual=%h required=5a", rx_data_out); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ferr_total actual=%0d required=1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int v0, e0;
    d = 8'h81;
    v0 = valid_cnt; e0 = err_cnt;
    rx_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_serial_in = d[4];
    repeat (3) @(posedge clk_in);
    #1;
    nrst_in = 1'b0;
    #1;
    checks++; if (rx_data_out !== 8'h00) begin failures++; $display("FAIL rstmid_data actual=%h required=00", rx_data_out); end
    checks++; if (rx_busy_out !== 1'b0) begin failures++; $display("FAIL rstmid_busy actual=%b required=0", rx_busy_out); end
    checks++; if (rx_valid_out !== 1'b0 || rx_frame_err_out !== 1'b0) begin failures++; $display("FAIL rstmid_pulses actual=%b%b required=00", rx_valid_out, rx_frame_err_out); end
    repeat (2) @(posedge clk_in);
    #1;
    nrst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    for (int i = 5; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    idle(16);
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL rstmid_no_valid actual=%0d required=0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL rstmid_no_err actual=%0d required=0", err_cnt - e0); end
    send_frame(8'h7E, 1'b1);
    idle(16);
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL rstmid_next_count actual=%0d required=1", rx_q.size()); end
    checks++; if (rx_data_out !== 8'h7E) begin failures++; $display("FAIL rstmid_next_data actual=%h required=7e", rx_data_out); end
  endtask

  initial begin
    checks = 0; failures = 0;
    valid_cnt = 0; err_cnt = 0; both_cnt = 0; busy_seen = 1'b0;
    nrst_in = 1'b0;
    rx_serial_in = 1'b1;
    @(posedge clk_in);
    #1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL valid_err_overlap actual=%0d required=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
